// File: rtl/mig_ui_arbiter.sv
// Two-requester round-robin arbiter in front of one MIG UI, with bounded bursts
// and a read-tag FIFO that steers returning read beats to their issuer.
module mig_ui_arbiter #(
  parameter int APP_DATA_WIDTH = 64,
  parameter int APP_ADDR_WIDTH = 33,
  parameter int MAX_BURST      = 16,
  parameter int LOG_TAG_DEPTH  = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            init_calib_complete,
  input  logic [1:0]                      req_en,
  input  logic [5:0]                      req_cmd,
  input  logic [2*APP_ADDR_WIDTH-1:0]     req_addr,
  input  logic [2*APP_DATA_WIDTH-1:0]     req_wdf_data,
  input  logic [1:0]                      req_wdf_wren,
  input  logic [2*APP_DATA_WIDTH/8-1:0]   req_wdf_mask,
  output logic [1:0]                      req_rdy,
  output logic [1:0]                      req_wdf_rdy,
  output logic [1:0]                      req_rd_data_valid,
  output logic [APP_DATA_WIDTH-1:0]       req_rd_data,
  input  logic                            app_rdy,
  input  logic                            app_wdf_rdy,
  input  logic                            app_rd_data_valid,
  input  logic [APP_DATA_WIDTH-1:0]       app_rd_data,
  output logic                            app_en,
  output logic                            app_wdf_wren,
  output logic                            app_wdf_end,
  output logic [2:0]                      app_cmd,
  output logic [APP_ADDR_WIDTH-1:0]       app_addr,
  output logic [APP_DATA_WIDTH-1:0]       app_wdf_data,
  output logic [APP_DATA_WIDTH/8-1:0]     app_wdf_mask,
  output logic [1:0]                      grant,
  output logic [LOG_TAG_DEPTH:0]          rd_outstanding,
  output logic                            err
);

  localparam int MASK_W    = APP_DATA_WIDTH / 8;
  localparam int TAG_DEPTH = 1 << LOG_TAG_DEPTH;
  localparam int BW        = $clog2(MAX_BURST + 1);
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [LOG_TAG_DEPTH:0] TAG_FULL_CNT = (LOG_TAG_DEPTH + 1)'(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t                   state;
  logic                     last_grant;
  logic [BW-1:0]            burst_cnt;

  logic                     tag_mem [TAG_DEPTH];
  logic [LOG_TAG_DEPTH-1:0] wr_ptr;
  logic [LOG_TAG_DEPTH-1:0] rd_ptr;
  logic [LOG_TAG_DEPTH:0]   tag_cnt;
  logic                     tag_empty;
  logic                     tag_full;

  logic                     owned;
  logic                     owner;
  logic                     o_en;
  logic                     o_wren;
  logic [2:0]               o_cmd;
  logic                     is_rd;
  logic                     block;
  logic                     accept;
  logic                     push;
  logic                     pop;
  logic                     end_grant;

  assign owned     = (state != IDLE);
  assign owner     = (state == GRANT1);
  assign tag_empty = (tag_cnt == '0);
  assign tag_full  = (tag_cnt == TAG_FULL_CNT);
  assign pop       = app_rd_data_valid & ~tag_empty;

  always_comb begin
    o_en   = owner ? req_en[1]       : req_en[0];
    o_wren = owner ? req_wdf_wren[1] : req_wdf_wren[0];
    o_cmd  = owner ? req_cmd[5:3]    : req_cmd[2:0];
    is_rd  = (o_cmd == CMD_RD);
    // A pop in the same cycle frees a slot, so a read may still enter a full FIFO.
    block  = tag_full & ~pop & is_rd;

    app_en       = owned & o_en & ~block;
    app_wdf_wren = owned & o_wren;
    app_wdf_end  = app_wdf_wren;
    app_cmd      = CMD_RD;
    app_addr     = '0;
    app_wdf_data = '0;
    app_wdf_mask = '0;
    req_rdy      = '0;
    req_wdf_rdy  = '0;
    if (owned) begin
      app_cmd      = o_cmd;
      app_addr     = owner ? req_addr[2*APP_ADDR_WIDTH-1:APP_ADDR_WIDTH]
                           : req_addr[APP_ADDR_WIDTH-1:0];
      app_wdf_data = owner ? req_wdf_data[2*APP_DATA_WIDTH-1:APP_DATA_WIDTH]
                           : req_wdf_data[APP_DATA_WIDTH-1:0];
      app_wdf_mask = owner ? req_wdf_mask[2*MASK_W-1:MASK_W]
                           : req_wdf_mask[MASK_W-1:0];
      req_rdy[owner]     = app_rdy & ~block;
      req_wdf_rdy[owner] = app_wdf_rdy;
    end

    accept    = app_en & app_rdy;
    push      = accept & is_rd;
    end_grant = (accept & (burst_cnt == BURST_LAST)) | ~o_en | ~init_calib_complete;

    req_rd_data_valid = '0;
    if (pop) req_rd_data_valid[tag_mem[rd_ptr]] = 1'b1;
  end

  assign req_rd_data    = app_rd_data;
  assign rd_outstanding = tag_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= 1'b1;
      burst_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (init_calib_complete && (req_en != 2'b00)) begin
            if (req_en[0] && (!req_en[1] || last_grant)) begin
              state <= GRANT0;
              grant <= 2'b01;
            end else begin
              state <= GRANT1;
              grant <= 2'b10;
            end
          end
        end
        default: begin
          if (end_grant) begin
            state      <= IDLE;
            grant      <= '0;
            burst_cnt  <= '0;
            last_grant <= owner;
          end else if (accept) begin
            burst_cnt <= burst_cnt + BW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= owner;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LOG_TAG_DEPTH'(1);
      if (pop)  rd_ptr <= rd_ptr + LOG_TAG_DEPTH'(1);
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + (LOG_TAG_DEPTH + 1)'(1);
        2'b01:   tag_cnt <= tag_cnt - (LOG_TAG_DEPTH + 1)'(1);
        default: tag_cnt <= tag_cnt;
      endcase
      if ((app_rd_data_valid & tag_empty) | (accept & (o_cmd == CMD_WR) & ~o_wren))
        err <= 1'b1;
    end
  end

endmodule

// File: doc/mig_ui_arbiter.md
Name: mig_ui_arbiter

Overview:
- Shares one MIG user interface (UI) between two sr_tg-style traffic generators, so that two encrypt/decrypt test streams can exercise one DDR controller.
- Round-robin arbitration with bounded command bursts; zero-latency mux of the granted requester onto the MIG command and write-data paths.
- A read-tag FIFO routes each returning read beat to the requester that issued it.
- Sits between the traffic generators and the MIG UI in the top level.

Parameters:
- APP_DATA_WIDTH, 64, DDR UI data width.
- APP_ADDR_WIDTH, 33, UI address width.
- MAX_BURST, 16, maximum commands accepted per grant (>=1).
- LOG_TAG_DEPTH, 5, log2 depth of the read-tag FIFO (32 entries).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- init_calib_complete  in  1  MIG calibration done; no grants while low.
- req_en  in  2  per-requester app_en; bit n = requester n.
- req_cmd  in  6  {cmd1,cmd0}, 3 bits each; 3'b000 = write, 3'b001 = read.
- req_addr  in  2*APP_ADDR_WIDTH  {addr1,addr0}.
- req_wdf_data  in  2*APP_DATA_WIDTH  {data1,data0}.
- req_wdf_wren  in  2  per-requester write-data enable.
- req_wdf_mask  in  2*APP_DATA_WIDTH/8  {mask1,mask0}.
- req_rdy  out  2  per-requester app_rdy.
- req_wdf_rdy  out  2  per-requester app_wdf_rdy.
- req_rd_data_valid  out  2  per-requester read valid.
- req_rd_data  out  APP_DATA_WIDTH  broadcast of app_rd_data.
- app_rdy, app_wdf_rdy, app_rd_data_valid  in  1 each  from MIG UI.
- app_rd_data  in  APP_DATA_WIDTH  from MIG UI.
- app_en, app_wdf_wren, app_wdf_end  out  1 each  to MIG UI.
- app_cmd  out  3  to MIG UI.
- app_addr  out  APP_ADDR_WIDTH  to MIG UI.
- app_wdf_data  out  APP_DATA_WIDTH  to MIG UI.
- app_wdf_mask  out  APP_DATA_WIDTH/8  to MIG UI.
- grant  out  2  one-hot current owner; 2'b00 = none.
- rd_outstanding  out  LOG_TAG_DEPTH+1  reads issued and not yet returned.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst==0 at a clk edge) has these results:
  - state IDLE, grant 0, last_grant points to requester 1 (so requester 0 wins first), burst count 0, tag FIFO empty, rd_outstanding 0, err 0.
  - The forced outputs follow: app_en 0, app_wdf_wren 0, app_cmd 3'b001, app_addr 0, app_wdf_data 0, app_wdf_mask 0, all req_* outputs 0.
- Reset mid-operation drops outstanding tags; any later valid beats raise err.
- States:
  - IDLE: grant 0.
  - If init_calib_complete==1 and any req_en is set, go to GRANT of the requester selected round-robin. Both requesting selects the one not equal to last_grant.
  - GRANT becomes visible the next cycle.
- GRANTn (n = owner), all combinational from the owner:
  - app_cmd, app_addr, app_wdf_data and app_wdf_mask come from requester n.
  - app_en = req_en[n] & ~block.
  - req_rdy[n] = app_rdy & ~block; req_wdf_rdy[n] = app_wdf_rdy.
  - app_wdf_wren = req_wdf_wren[n]; app_wdf_end = app_wdf_wren.
  - The non-owner sees req_rdy = req_wdf_rdy = 0.
  - block = tag FIFO full & req_cmd[n]==3'b001.
- Accept = app_en & app_rdy. Each accept increments the burst count.
- GRANTn goes to IDLE (burst count cleared, last_grant = n) when any of these holds:
  - an accept makes the count reach MAX_BURST;
  - req_en[n]==0;
  - init_calib_complete==0.
- Exactly one dead cycle (IDLE) lies between consecutive grants, even to the same requester.
- Write data in flight at grant end is not tracked. Requesters must present wdf_wren in the same cycle as the write command; a write accepted with app_wdf_wren==0 sets err.
- Tag FIFO:
  - An accepted read pushes owner id n.
  - app_rd_data_valid pops the head; req_rd_data_valid[head]=app_rd_data_valid, with zero latency.
  - Simultaneous push and pop are legal, including when the FIFO is full.
  - Pointers wrap modulo 2^LOG_TAG_DEPTH.
  - rd_outstanding = push count minus pop count, saturating within 0..2^LOG_TAG_DEPTH.
- app_rd_data_valid with the FIFO empty: no req valid, err set; err clears only on reset.
- Unknown cmd values (not 000/001) pass through unchanged and do not push a tag.

Test Plan:
- Single requester: r0 issues 4 writes then 4 reads, r1 idle. The following must hold:
  - grant goes 01 one cycle after req_en[0];
  - 8 app_en accepts;
  - all 4 read beats return with req_rd_data_valid=01;
  - rd_outstanding returns to 0.
- Both requesting continuously, MAX_BURST=16, app_rdy=1: grants alternate 01, 00, 10, 00, 01, and each grant carries exactly 16 accepts.
- Interleaved reads: r0 issues 3 reads, then r1 issues 2 reads. MIG returns 5 beats in order, which must route to r0, r0, r0, r1, r1.
- Tag full: 32 reads outstanding, then r0 presents a 33rd read. Required response:
  - app_en=0 and req_rdy[0]=0 until one valid pops;
  - the read is accepted in the same cycle as the pop;
  - rd_outstanding stays at 32.
- app_rdy deasserted for 5 cycles mid-burst: the command is held, the burst count does not advance, and grant is not lost.
- Reset mid-burst with 3 reads outstanding, then 3 valid beats arrive. Required response: no req_rd_data_valid, err=1 from the first orphan beat, grant=00 during reset.
